// File: rtl/stream_pkg.sv
// Shared types for the stream accumulator: FSM state encoding and beat-count width.
package stream_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CNT_W = 8;
endpackage

// File: rtl/accum_add.sv
// Combinational group adder; saturates to all-ones when STREAM_ACCUM_SAT_EN is defined,
// otherwise wraps modulo 2^WIDTH and reports no saturation.
module accum_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat_in,
    output logic [WIDTH-1:0] sum,
    output logic             sat_out
);
`ifdef STREAM_ACCUM_SAT_EN
    logic [WIDTH:0] w_full;

    always_comb begin
        w_full  = {1'b0, a} + {1'b0, b};
        sum     = w_full[WIDTH-1:0];
        sat_out = sat_in;
        if (w_full[WIDTH]) begin
            sum     = '1;
            sat_out = 1'b1;
        end
    end
`else
    always_comb begin
        sum     = a + b;
        sat_out = sat_in & 1'b0;
    end
`endif
endmodule

// File: rtl/stream_accum.sv
// Groups up to BEATS input beats into one summed result with a one-cycle result latency.
// Optional saturation of the sum is enabled by defining STREAM_ACCUM_SAT_EN.
//
// state | meaning
// IDLE  | no partial group
// ACCUM | partial group held
// DONE  | result held on outputs until taken
module stream_accum
    import stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BEATS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    input  logic             out_ready,
    output logic             out_sat
);
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;

    logic             w_in_fire;
    logic             w_start;
    logic             w_close;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_sum;
    logic             w_sat;
    logic [CNT_W-1:0] w_count_nxt;

    assign in_ready  = (r_state != DONE) || out_ready;
    assign w_in_fire = in_valid && in_ready;

    // A beat outside ACCUM always opens a fresh group; in DONE it can only be
    // accepted when the held result is taken on the same edge.
    assign w_start     = (r_state != ACCUM);
    assign w_base      = w_start ? '0 : r_sum;
    assign w_count_nxt = w_start ? CNT_W'(1) : r_count + CNT_W'(1);
    assign w_close     = in_last || (w_count_nxt == BEATS_C);

    accum_add #(.WIDTH(WIDTH)) u_add (
        .a       (w_base),
        .b       (in_data),
        .sat_in  (w_start ? 1'b0 : r_sat),
        .sum     (w_sum),
        .sat_out (w_sat)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_in_fire) w_state_nxt = w_close ? DONE : ACCUM;
            end
            DONE: begin
                if (w_in_fire)      w_state_nxt = w_close ? DONE : ACCUM;
                else if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sum   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_fire) begin
                r_sum   <= w_sum;
                r_count <= w_count_nxt;
                r_sat   <= w_sat;
            end
        end
    end

    assign out_valid = (r_state == DONE);
    assign out_data  = r_sum;
    assign out_count = r_count;
    assign out_sat   = r_sat && (r_state == DONE);
endmodule

// File: tb/tb_stream_accum.sv
// Directed bench for stream_accum: full groups, early close, backpressure, overflow,
// mid-group reset and idle gaps, with hand-computed expectations.
module tb_stream_accum;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_count;
    logic        out_ready;
    logic        out_sat;

    int total = 0;
    int bad   = 0;
    int results;

    stream_accum #(.WIDTH(32), .BEATS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ready (out_ready),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data,           32'd0);
        chk("rst_out_count", {24'b0, out_count}, 32'd0);
        chk("rst_out_sat",   {31'b0, out_sat},   32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);

        // full group of four
        drive(1'b1, 32'd1, 1'b0); step();
        drive(1'b1, 32'd2, 1'b0); step();
        drive(1'b1, 32'd3, 1'b0); step();
        chk("full_no_early_valid", {31'b0, out_valid}, 32'd0);
        drive(1'b1, 32'd4, 1'b0); step();
        chk("full_valid", {31'b0, out_valid}, 32'd1);
        chk("full_data",  out_data,           32'd10);
        chk("full_count", {24'b0, out_count}, 32'd4);

        // result taken while the next group's first beat arrives, then early close
        drive(1'b1, 32'd5, 1'b0); step();
        chk("early_accum_valid", {31'b0, out_valid}, 32'd0);
        drive(1'b1, 32'd7, 1'b1); step();
        chk("early_valid", {31'b0, out_valid}, 32'd1);
        chk("early_data",  out_data,           32'd12);
        chk("early_count", {24'b0, out_count}, 32'd2);
        drive(1'b0, 32'd0, 1'b0); step();
        chk("early_taken", {31'b0, out_valid}, 32'd0);

        // backpressure: result held, offered beats refused
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 1'b0); step();
        drive(1'b1, 32'd1, 1'b1); step();
        drive(1'b1, 32'd99, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_data",     out_data,          32'd2);
            step();
        end
        chk("bp_valid_held", {31'b0, out_valid}, 32'd1);
        chk("bp_count_held", {24'b0, out_count}, 32'd2);
        out_ready = 1'b1;
        drive(1'b1, 32'd9, 1'b1);
        #1;
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_next_data",  out_data,           32'd9);
        chk("bp_next_count", {24'b0, out_count}, 32'd1);
        drive(1'b0, 32'd0, 1'b0); step();
        chk("bp_drained", {31'b0, out_valid}, 32'd0);

        // overflow
        drive(1'b1, 32'hFFFF_FFF0, 1'b0); step();
        drive(1'b1, 32'h0000_0020, 1'b1); step();
        chk("ovf_valid", {31'b0, out_valid}, 32'd1);
        chk("ovf_count", {24'b0, out_count}, 32'd2);
`ifdef STREAM_ACCUM_SAT_EN
        chk("ovf_data", out_data,         32'hFFFF_FFFF);
        chk("ovf_sat",  {31'b0, out_sat}, 32'd1);
`else
        chk("ovf_data", out_data,         32'h0000_0010);
        chk("ovf_sat",  {31'b0, out_sat}, 32'd0);
`endif
        drive(1'b0, 32'd0, 1'b0); step();

        // reset mid-group discards the partial sum
        drive(1'b1, 32'd1, 1'b0); step();
        drive(1'b1, 32'd2, 1'b0); step();
        drive(1'b0, 32'd0, 1'b0);
        rst = 1'b1; step();
        rst = 1'b0;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_count", {24'b0, out_count}, 32'd0);
        chk("mid_rst_data",  out_data,           32'd0);
        drive(1'b1, 32'd3, 1'b0); step();
        drive(1'b1, 32'd4, 1'b0); step();
        drive(1'b1, 32'd5, 1'b0); step();
        drive(1'b1, 32'd6, 1'b0); step();
        chk("mid_rst_res_valid", {31'b0, out_valid}, 32'd1);
        chk("mid_rst_res_data",  out_data,           32'd18);
        chk("mid_rst_res_count", {24'b0, out_count}, 32'd4);
        chk("mid_rst_res_sat",   {31'b0, out_sat},   32'd0);
        drive(1'b0, 32'd0, 1'b0); step();

        // idle gaps; in_last with in_valid low must be ignored
        results = 0;
        for (int b = 1; b <= 4; b++) begin
            drive(1'b1, b, 1'b0); step();
            if (out_valid) results++;
            if (b < 4) begin
                for (int g = 0; g < 2; g++) begin
                    drive(1'b0, 32'hDEAD_BEEF, 1'b1); step();
                    if (out_valid) results++;
                end
            end
        end
        chk("gap_data",  out_data,           32'd10);
        chk("gap_count", {24'b0, out_count}, 32'd4);
        drive(1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            if (out_valid) results++;
        end
        chk("gap_results", results, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_accum.md
STREAM_ACCUM -- requirements
Module: stream_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data and sum width in bits.
REQ-002 SHALL have parameter BEATS, default 4, meaning maximum beats per group (legal range 1..255).
REQ-003 SHALL have ports, one per line:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_data  input  WIDTH  upstream beat payload.
- in_last  input  1  closes the current group early.
- in_ready  output  1  block accepts a beat this cycle.
- out_valid  output  1  group result valid.
- out_data  output  WIDTH  group sum.
- out_count  output  8  number of beats in the group.
- out_ready  input  1  downstream accepts the result.
- out_sat  output  1  saturation flag; see Configuration.

Function
REQ-004 SHALL treat a beat as accepted when in_valid && in_ready at a rising edge, and a result as taken when out_valid && out_ready at a rising edge.
REQ-005 SHALL implement three states:
- IDLE: no partial group.
- ACCUM: partial group held.
- DONE: result held on outputs.
REQ-006 SHALL drive in_ready = (state != DONE) || out_ready; this combinational path gives one beat per cycle.
REQ-007 SHALL, on an accepted beat in IDLE or DONE (DONE only if the result is taken that edge), load sum = in_data and count = 1.
REQ-008 SHALL, on an accepted beat in ACCUM, set sum = sum + in_data, truncated to WIDTH bits (wrap), and count = count + 1.
REQ-009 SHALL close the group on the accepting edge when in_last = 1 or the new count equals BEATS, and enter DONE.
REQ-010 SHALL otherwise enter ACCUM after an accepted beat that does not close the group.
REQ-011 SHALL assert out_valid only in DONE, with out_data = sum and out_count = count, held stable until taken.
REQ-012 SHALL, when the result is taken with no beat accepted, return to IDLE.
REQ-013 SHALL have a latency of exactly one cycle: out_valid rises the cycle after the closing beat is accepted.
REQ-014 SHALL, when the result is taken and a beat is accepted on the same edge, start a new group per REQ-007; with BEATS=1 or in_last=1 it stays in DONE with no bubble.
REQ-015 SHALL hold all state when in_valid = 0, including in ACCUM indefinitely.
REQ-016 SHALL ignore in_data and in_last when no beat is accepted.

Reset
REQ-017 SHALL, while rst = 1 at a rising edge, set state = IDLE, sum = 0, count = 0, and the saturation flag = 0, discarding any partial group or held result.
REQ-018 SHALL drive out_valid = 0, out_data = 0, out_count = 0, out_sat = 0 and in_ready = 1 in the first cycle after reset.

Configuration
REQ-019 SHALL, with STREAM_ACCUM_SAT_EN defined, clamp the sum to all-ones on unsigned overflow and set a sticky per-group flag, driven on out_sat in DONE and cleared when the next group starts.
REQ-020 SHALL, without STREAM_ACCUM_SAT_EN, wrap the sum modulo 2^WIDTH and tie out_sat to 0.

Structure
REQ-021 SHALL place the state enum (IDLE, ACCUM, DONE) and the count width constant (8) in a shared package, stream_pkg.
REQ-022 SHALL implement the adder and saturation logic as one sub-module, accum_add (combinational: a, b, sat_in -> sum, sat_out).

Verification
REQ-023 SHALL cover a full group: beats 1,2,3,4 back-to-back with out_ready=1 -> one cycle later out_valid=1, out_data=10, out_count=4.
REQ-024 SHALL cover an early close: beats 5 then 7 with in_last=1 on the 7 -> out_data=12, out_count=2.
REQ-025 SHALL cover backpressure: a group closes with out_ready=0 for 3 cycles -> in_ready=0, out_data stable; on out_ready=1 with in_valid=1 data 9 and in_last=1 -> next cycle out_data=9, out_count=1, out_valid held high.
REQ-026 SHALL cover overflow: beats 32'hFFFF_FFF0 and 32'h20 with in_last=1 -> without the macro out_data=32'h10, out_sat=0; with it out_data=32'hFFFF_FFFF, out_sat=1.
REQ-027 SHALL cover reset mid-group: beats 1,2 then rst=1 for one cycle, then beats 3,4,5,6 -> out_data=18, out_count=4.
REQ-028 SHALL cover idle gaps: beats 1,2,3,4 with 2 idle cycles between each -> out_data=10, exactly one result.
